// File: rtl/pcie_dispatch_arbiter.sv
// Pops words from one upstream FIFO and forwards each to one of NUM_CH downstream FIFOs,
// either round-robin skipping almost-full channels (MODE 0) or by an in-word destination (MODE 1).
module pcie_dispatch_arbiter #(
  parameter int NUM_CH   = 4,
  parameter int DATA_W   = 12,
  parameter int MODE     = 0,
  parameter int DEST_LSB = 10,
  parameter int STALL_W  = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                empty,
  input  logic [DATA_W-1:0]   data_in,
  input  logic [NUM_CH-1:0]   almost_full,
  output logic                pop,
  output logic [NUM_CH-1:0]   push,
  output logic [DATA_W-1:0]   data_out,
  output logic                dest_err,
  output logic [STALL_W-1:0]  stall_cnt
);

  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int NP = 1 << CW;
  localparam logic [CW:0]   NUM_CH_L = (CW+1)'(NUM_CH);
  localparam logic [CW-1:0] LAST_CH  = CW'(NUM_CH - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CAPTURE, S_BLOCKED} state_t;

  function automatic logic [STALL_W-1:0] sat_inc(input logic [STALL_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [CW-1:0] ch_inc(input logic [CW-1:0] c);
    return (c == LAST_CH) ? '0 : c + 1'b1;
  endfunction

  // Returns {found, channel}: first channel at or after start that is not almost full.
  function automatic logic [CW:0] rr_scan(input logic [NUM_CH-1:0] af,
                                          input logic [CW-1:0]     start);
    logic          found;
    logic [CW-1:0] c;
    logic [CW-1:0] sel;
    found = 1'b0;
    sel   = '0;
    c     = start;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!found && !af[c]) begin
        found = 1'b1;
        sel   = c;
      end
      c = ch_inc(c);
    end
    return {found, sel};
  endfunction

  state_t              state_q, state_d;
  logic [CW-1:0]       rr_q, rr_d;
  logic [DATA_W-1:0]   hold_q, hold_d;
  logic [DATA_W-1:0]   data_out_q, data_out_d;
  logic                pop_q, pop_d;
  logic                dest_err_q, dest_err_d;
  logic [NUM_CH-1:0]   push_q, push_d;
  logic [STALL_W-1:0]  stall_q, stall_d;

  logic [DATA_W-1:0]   src;
  logic [CW-1:0]       dest;
  logic [NP-1:0]       af_ext;
  logic [CW:0]         scan;
  logic [CW-1:0]       tgt;
  logic                tgt_free;
  logic                tgt_bad;
  logic                do_push;
  logic                go_on;

  // Target selection: CAPTURE looks at the fresh FIFO word, BLOCKED at the held one.
  always_comb begin
    src    = (state_q == S_CAPTURE) ? data_in : hold_q;
    dest   = src[DEST_LSB +: CW];
    af_ext = NP'(almost_full);
    scan   = rr_scan(almost_full, rr_q);
    if (MODE == 0) begin
      tgt      = scan[CW-1:0];
      tgt_bad  = 1'b0;
      tgt_free = scan[CW];
    end else begin
      tgt      = dest;
      tgt_bad  = ({1'b0, dest} >= NUM_CH_L);
      tgt_free = !tgt_bad && !af_ext[dest];
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    hold_d     = hold_q;
    data_out_d = data_out_q;
    stall_d    = stall_q;
    pop_d      = 1'b0;
    push_d     = '0;
    dest_err_d = 1'b0;
    do_push    = 1'b0;
    go_on      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop_d   = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: state_d = S_CAPTURE;
      S_CAPTURE: begin
        hold_d = data_in;
        if (tgt_bad) begin
          dest_err_d = 1'b1;
          go_on      = 1'b1;
        end else if (tgt_free) begin
          do_push = 1'b1;
          go_on   = 1'b1;
        end else begin
          state_d = S_BLOCKED;
        end
      end
      S_BLOCKED: begin
        stall_d = sat_inc(stall_q);
        if (tgt_free) begin
          do_push = 1'b1;
          go_on   = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (do_push) begin
      push_d     = {{(NUM_CH-1){1'b0}}, 1'b1} << tgt;
      data_out_d = src;
      rr_d       = ch_inc(tgt);
    end
    // Back-to-back: a non-empty FIFO is popped in the same cycle the word leaves.
    if (go_on) begin
      if (!empty) begin
        pop_d   = 1'b1;
        state_d = S_WAIT;
      end else begin
        state_d = S_IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      rr_q       <= '0;
      hold_q     <= '0;
      data_out_q <= '0;
      pop_q      <= 1'b0;
      push_q     <= '0;
      dest_err_q <= 1'b0;
      stall_q    <= '0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      hold_q     <= hold_d;
      data_out_q <= data_out_d;
      pop_q      <= pop_d;
      push_q     <= push_d;
      dest_err_q <= dest_err_d;
      stall_q    <= stall_d;
    end
  end

  assign pop       = pop_q;
  assign push      = push_q;
  assign data_out  = data_out_q;
  assign dest_err  = dest_err_q;
  assign stall_cnt = stall_q;

endmodule

// File: tb/tb_pcie_dispatch_arbiter.sv
// Directed bench: round-robin instance (A), destination-routed instances with 4 (B) and
// 3 channels plus a 4-bit stall counter (C), each fed by a small upstream FIFO model.
module tb_pcie_dispatch_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstn;
  int   cyc = 0;
  int   passed = 0;
  int   total = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int ch; int d; int cyc;} ev_t;

  function automatic ev_t mkev(input int ch, input int d, input int c);
    ev_t e;
    e.ch = ch; e.d = d; e.cyc = c;
    return e;
  endfunction

  function automatic int oh_idx(input logic [15:0] v);
    int idx = -1;
    int cnt = 0;
    for (int i = 0; i < 16; i++) if (v[i]) begin idx = i; cnt++; end
    return (cnt == 1) ? idx : -1;
  endfunction

  function automatic ev_t ev_at(input ev_t q[$], input int i);
    if (i < q.size()) return q[i];
    return mkev(-99, -99, -99);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Instance A: MODE 0, 4 channels
  logic [11:0] words_a [32];
  int          n_a = 0, rd_a = 0;
  logic [11:0] din_a = '0;
  logic        empty_a, pop_a, derr_a;
  logic [3:0]  af_a, push_a;
  logic [11:0] dout_a;
  logic [15:0] stall_a;
  assign empty_a = (rd_a >= n_a);
  always @(posedge clk) if (pop_a) begin din_a <= words_a[rd_a[4:0]]; rd_a <= rd_a + 1; end

  pcie_dispatch_arbiter #(.NUM_CH(4), .DATA_W(12), .MODE(0), .DEST_LSB(10), .STALL_W(16)) u_a (
    .clk(clk), .reset(rstn), .empty(empty_a), .data_in(din_a), .almost_full(af_a),
    .pop(pop_a), .push(push_a), .data_out(dout_a), .dest_err(derr_a), .stall_cnt(stall_a));

  // Instance B: MODE 1, 4 channels
  logic [11:0] words_b [32];
  int          n_b = 0, rd_b = 0;
  logic [11:0] din_b = '0;
  logic        empty_b, pop_b, derr_b;
  logic [3:0]  af_b, push_b;
  logic [11:0] dout_b;
  logic [15:0] stall_b;
  assign empty_b = (rd_b >= n_b);
  always @(posedge clk) if (pop_b) begin din_b <= words_b[rd_b[4:0]]; rd_b <= rd_b + 1; end

  pcie_dispatch_arbiter #(.NUM_CH(4), .DATA_W(12), .MODE(1), .DEST_LSB(10), .STALL_W(16)) u_b (
    .clk(clk), .reset(rstn), .empty(empty_b), .data_in(din_b), .almost_full(af_b),
    .pop(pop_b), .push(push_b), .data_out(dout_b), .dest_err(derr_b), .stall_cnt(stall_b));

  // Instance C: MODE 1, 3 channels, 4-bit stall counter
  logic [11:0] words_c [32];
  int          n_c = 0, rd_c = 0;
  logic [11:0] din_c = '0;
  logic        empty_c, pop_c, derr_c;
  logic [2:0]  af_c, push_c;
  logic [11:0] dout_c;
  logic [3:0]  stall_c;
  assign empty_c = (rd_c >= n_c);
  always @(posedge clk) if (pop_c) begin din_c <= words_c[rd_c[4:0]]; rd_c <= rd_c + 1; end

  pcie_dispatch_arbiter #(.NUM_CH(3), .DATA_W(12), .MODE(1), .DEST_LSB(10), .STALL_W(4)) u_c (
    .clk(clk), .reset(rstn), .empty(empty_c), .data_in(din_c), .almost_full(af_c),
    .pop(pop_c), .push(push_c), .data_out(dout_c), .dest_err(derr_c), .stall_cnt(stall_c));

  ev_t pl_a[$], pl_b[$], pl_c[$];
  int  popl_a[$], el_c[$];

  always @(negedge clk) begin
    if (push_a != 0) pl_a.push_back(mkev(oh_idx(16'(push_a)), int'(dout_a), cyc));
    if (push_b != 0) pl_b.push_back(mkev(oh_idx(16'(push_b)), int'(dout_b), cyc));
    if (push_c != 0) pl_c.push_back(mkev(oh_idx(16'(push_c)), int'(dout_c), cyc));
    if (pop_a) popl_a.push_back(cyc);
    if (derr_c) el_c.push_back(cyc);
  end

  task automatic add_a(input logic [11:0] w); words_a[n_a] = w; n_a++; endtask
  task automatic add_b(input logic [11:0] w); words_b[n_b] = w; n_b++; endtask
  task automatic add_c(input logic [11:0] w); words_c[n_c] = w; n_c++; endtask

  initial begin
    int b, pb;
    int exp_ch2 [4];
    ev_t e;
    rstn = 1'b0;
    af_a = '0; af_b = '0; af_c = '0;
    repeat (3) @(negedge clk);
    chk("rst_pop", pop_a, 0);
    chk("rst_push", push_a, 0);
    chk("rst_dout", dout_a, 0);
    chk("rst_derr", derr_a, 0);
    chk("rst_stall", stall_a, 0);
    chk("rst_push_c", push_c, 0);
    rstn = 1'b1;
    @(negedge clk);

    // T1: eight words, free-running round robin
    b = pl_a.size(); pb = popl_a.size();
    for (int i = 0; i < 8; i++) add_a(12'(i + 1));
    repeat (24) @(negedge clk);
    chk("t1_count", pl_a.size() - b, 8);
    chk("t1_pops", popl_a.size() - pb, 8);
    for (int k = 0; k < 8; k++) begin
      e = ev_at(pl_a, b + k);
      chk($sformatf("t1_ch%0d", k), e.ch, k % 4);
      chk($sformatf("t1_data%0d", k), e.d, k + 1);
    end
    chk("t1_latency", ev_at(pl_a, b).cyc - popl_a[pb], 2);
    chk("t1_spacing", ev_at(pl_a, b + 7).cyc - ev_at(pl_a, b).cyc, 14);
    chk("t1_dout_hold", dout_a, 12'h008);
    chk("t1_push_idle", push_a, 0);

    // T2: channel 1 almost full throughout
    b = pl_a.size();
    af_a = 4'b0010;
    for (int i = 0; i < 4; i++) add_a(12'(16'h011 + i));
    repeat (16) @(negedge clk);
    exp_ch2 = '{0, 2, 3, 0};
    chk("t2_count", pl_a.size() - b, 4);
    for (int k = 0; k < 4; k++) begin
      e = ev_at(pl_a, b + k);
      chk($sformatf("t2_ch%0d", k), e.ch, exp_ch2[k]);
      chk($sformatf("t2_data%0d", k), e.d, 16'h011 + k);
    end
    af_a = 4'b0000;

    // T3: all full for 5 decision cycles, then only channel 3 frees up
    b = pl_a.size(); pb = popl_a.size();
    af_a = 4'b1111;
    add_a(12'h021);
    add_a(12'h022);
    repeat (7) @(negedge clk);
    af_a = 4'b0111;
    @(negedge clk);
    chk("t3_stall", stall_a, 5);
    chk("t3_push_ch3", push_a, 4'b1000);
    af_a = 4'b0000;
    repeat (10) @(negedge clk);
    chk("t3_count", pl_a.size() - b, 2);
    e = ev_at(pl_a, b);
    chk("t3_ch_first", e.ch, 3);
    chk("t3_data_first", e.d, 12'h021);
    chk("t3_wait", e.cyc - popl_a[pb], 7);
    chk("t3_no_pop_blocked", popl_a[pb + 1] - popl_a[pb], 7);
    e = ev_at(pl_a, b + 1);
    chk("t3_ch_second", e.ch, 0);
    chk("t3_data_second", e.d, 12'h022);
    chk("t3_stall_kept", stall_a, 5);

    // T5: reset while a word is held in BLOCKED
    b = pl_a.size();
    af_a = 4'b1111;
    add_a(12'h031);
    add_a(12'h032);
    repeat (4) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    chk("t5_pop", pop_a, 0);
    chk("t5_push", push_a, 0);
    chk("t5_dout", dout_a, 0);
    chk("t5_derr", derr_a, 0);
    chk("t5_stall", stall_a, 0);
    rstn = 1'b1;
    af_a = 4'b0000;
    repeat (10) @(negedge clk);
    chk("t5_count", pl_a.size() - b, 1);
    e = ev_at(pl_a, b);
    chk("t5_ch", e.ch, 0);
    chk("t5_data", e.d, 12'h032);

    // T4: destination routing
    b = pl_b.size();
    add_b(12'h400);
    add_b(12'hC05);
    add_b(12'h807);
    repeat (12) @(negedge clk);
    chk("t4_count", pl_b.size() - b, 3);
    e = ev_at(pl_b, b);
    chk("t4_ch0", e.ch, 1);
    chk("t4_d0", e.d, 12'h400);
    e = ev_at(pl_b, b + 1);
    chk("t4_ch1", e.ch, 3);
    chk("t4_d1", e.d, 12'hC05);
    e = ev_at(pl_b, b + 2);
    chk("t4_ch2", e.ch, 2);
    chk("t4_d2", e.d, 12'h807);

    // T4: out-of-range destination with three channels
    b = pl_c.size(); pb = el_c.size();
    add_c(12'hC00);
    repeat (6) @(negedge clk);
    chk("t4_err_pulses", el_c.size() - pb, 1);
    chk("t4_err_nopush", pl_c.size() - b, 0);
    add_c(12'h805);
    repeat (6) @(negedge clk);
    chk("t4_after_err_count", pl_c.size() - b, 1);
    e = ev_at(pl_c, b);
    chk("t4_after_err_ch", e.ch, 2);
    chk("t4_after_err_d", e.d, 12'h805);

    // T6: stall counter saturation
    b = pl_c.size();
    af_c = 3'b100;
    add_c(12'h800);
    repeat (25) @(negedge clk);
    chk("t6_stall_sat", stall_c, 4'hF);
    chk("t6_blocked_nopush", pl_c.size() - b, 0);
    af_c = 3'b000;
    repeat (4) @(negedge clk);
    chk("t6_count", pl_c.size() - b, 1);
    e = ev_at(pl_c, b);
    chk("t6_ch", e.ch, 2);
    chk("t6_d", e.d, 12'h800);
    chk("t6_stall_kept", stall_c, 4'hF);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
